// File: rtl/weight_bank.sv
// weight_bank: sequentially loaded weight store with full snapshot and registered random read
module weight_bank #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 17,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [DWIDTH-1:0]       load_data,
    output logic                    load_ready,
    input  logic                    clear,
    input  logic                    enable,
    output logic [DEPTH*DWIDTH-1:0] params,
    output logic                    params_valid,
    output logic                    loaded,
    output logic [AW:0]             load_count,
    input  logic [AW-1:0]           rd_addr,
    output logic [DWIDTH-1:0]       rd_data
);
    localparam logic [0:0]  LOAD    = 1'b0;
    localparam logic [0:0]  READY   = 1'b1;
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    logic [0:0]              state;
    logic [DWIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*DWIDTH-1:0] snap;
    logic                    accept;
    assign load_ready = state == LOAD && !rst;
    assign accept     = load_valid && load_ready && !clear;
    assign loaded     = state == READY;
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_snap
            assign snap[i*DWIDTH +: DWIDTH] = mem[i];
        end
    endgenerate
    // storage is never reset; only accepted loads write it
    always_ff @(posedge clk)
        if (accept) mem[load_count[AW-1:0]] <= load_data;
    // load progress and LOAD/READY state; last accepted word moves to READY
    always_ff @(posedge clk)
        if (rst || clear) begin
            state      <= LOAD;
            load_count <= '0;
        end else if (accept) begin
            load_count <= load_count + 1'b1;
            if (load_count == LAST) state <= READY;
        end
    // snapshot of the whole bank, taken only from a complete load
    always_ff @(posedge clk)
        if (rst) begin
            params       <= '0;
            params_valid <= 1'b0;
        end else if (clear) begin
            params_valid <= 1'b0;
        end else if (enable && state == READY) begin
            params       <= snap;
            params_valid <= 1'b1;
        end
    // registered read; same-edge writes are not visible, out-of-range reads return zero
    always_ff @(posedge clk)
        if (rst) rd_data <= '0;
        else rd_data <= ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: randomized scoreboard bench for weight_bank against a behavioural model
module tb_weight_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] params;
    logic        params_valid;
    logic        loaded;
    logic [2:0]  load_count;
    logic [1:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        lr2, pv2, ld2;
    logic [39:0] p2;
    logic [3:0]  lc2;
    logic [2:0]  rd_addr2 = 3'd5;
    logic [7:0]  rd_data2;

    typedef struct {
        logic [2:0]  cnt;
        bit          ld;
        bit          lr;
        bit          pv;
        logic [31:0] p;
        bit          rc;
        logic [7:0]  rd;
        bit          kc;
        logic [31:0] kp;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt = 0;
    bit          full = 0;
    logic [7:0]  m[4];
    bit          w[4] = '{default: 0};
    logic [7:0]  pm[4] = '{default: 8'h00};
    bit          pv = 0;

    always #5 clk = ~clk;

    weight_bank #(.DWIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .clear(clear), .enable(enable), .params(params),
        .params_valid(params_valid), .loaded(loaded), .load_count(load_count),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    weight_bank #(.DWIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .load_valid(1'b0), .load_data(8'h00),
        .load_ready(lr2), .clear(1'b0), .enable(1'b0), .params(p2),
        .params_valid(pv2), .loaded(ld2), .load_count(lc2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit lv, input logic [7:0] d, input bit c,
                       input bit e, input logic [1:0] a, input bit kc = 0,
                       input logic [31:0] kp = 0);
        exp_t x;
        @(negedge clk);
        rst = r; load_valid = lv; load_data = d; clear = c; enable = e; rd_addr = a;
        rd_addr2 = 3'($urandom_range(5, 7));
        x.rd = r ? 8'h00 : m[a];
        x.rc = r || w[a];
        if (r) begin
            cnt = 0; full = 0; pv = 0; pm = '{default: 8'h00};
        end else if (c) begin
            cnt = 0; full = 0; pv = 0;
        end else begin
            if (e && full) begin
                pm = m; pv = 1;
            end
            if (lv && !full) begin
                m[cnt] = d; w[cnt] = 1; cnt++; full = cnt == 4;
            end
        end
        x.cnt = 3'(cnt);
        x.ld  = full;
        x.lr  = !full && !r;
        x.pv  = pv;
        x.p   = {pm[3], pm[2], pm[1], pm[0]};
        x.kc  = kc;
        x.kp  = kp;
        q.push_back(x);
    endtask

    // monitor: one expectation per clock edge, sampled just after the edge
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("load_count", 32'(load_count), 32'(x.cnt));
            chk("loaded", 32'(loaded), 32'(x.ld));
            chk("load_ready", 32'(load_ready), 32'(x.lr));
            chk("params_valid", 32'(params_valid), 32'(x.pv));
            chk("params", params, x.p);
            if (x.rc) chk("rd_data", 32'(rd_data), 32'(x.rd));
            chk("rd_data_oob", 32'(rd_data2), 32'h0);
            if (x.kc) chk("params_const", params, x.kp);
        end
    end

    initial begin
        cyc(1, 0, 8'h00, 0, 0, 2'd0);
        cyc(1, 0, 8'h00, 0, 0, 2'd0, 1, 32'h0);
        cyc(0, 1, 8'h11, 0, 0, 2'd0);
        cyc(0, 1, 8'h22, 0, 0, 2'd0);
        cyc(0, 0, 8'h00, 0, 1, 2'd0, 1, 32'h0);
        cyc(0, 1, 8'h33, 0, 0, 2'd0);
        cyc(0, 1, 8'h44, 0, 0, 2'd0);
        cyc(0, 1, 8'h55, 0, 1, 2'd2, 1, 32'h44332211);
        cyc(0, 0, 8'h00, 0, 0, 2'd3, 1, 32'h44332211);
        cyc(0, 1, 8'h99, 1, 0, 2'd0, 1, 32'h44332211);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'hA1 + 8'(i), 0, 0, 2'(i));
        cyc(0, 0, 8'h00, 0, 1, 2'd0, 1, 32'hA4A3A2A1);
        cyc(0, 0, 8'h00, 1, 1, 2'd1, 1, 32'hA4A3A2A1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'hC1 + 8'(i), 0, 0, 2'd0);
        cyc(1, 1, 8'hC4, 1, 1, 2'd0, 1, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'hB1 + 8'(i), 0, 0, 2'd3);
        cyc(0, 0, 8'h00, 0, 1, 2'd0, 1, 32'hB4B3B2B1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 2'($urandom));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
